// File: rtl/unrank_pkg.sv
// Shared constants, state encoding and binomial helpers for the combinadic unranker.
package unrank_pkg;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

    function automatic longint unsigned fact(input int n);
        longint unsigned acc;
        acc = 1;
        for (int i = 2; i <= n; i++) begin
            acc = acc * longint'(i);
        end
        return acc;
    endfunction

    function automatic int unsigned binom(input int n, input int k);
        if (k < 0 || k > n) begin
            return 0;
        end
        return int'(fact(n) / (fact(k) * fact(n - k)));
    endfunction

    localparam int DEF_NUM_WIDTH = 10;
    localparam int DEF_ROWS_NUM  = 13;
    localparam int DEF_K_MAX     = 4;
    localparam int DEF_ROW_WIDTH = clog2(DEF_ROWS_NUM);
    localparam int DEF_K_WIDTH   = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        EMIT,
        FIN
    } state_t;

    // Number of k-subsets of the row range; a rank must stay strictly below this.
    localparam int unsigned BOUND [0:DEF_K_MAX] = '{
        binom(DEF_ROWS_NUM, 0),
        binom(DEF_ROWS_NUM, 1),
        binom(DEF_ROWS_NUM, 2),
        binom(DEF_ROWS_NUM, 3),
        binom(DEF_ROWS_NUM, 4)
    };

endpackage

// File: rtl/unrank_colbank.sv
// Per-column binomial search for every k, plus the mux that picks the active column j.
module unrank_colbank
    import unrank_pkg::*;
#(
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int ROWS_NUM  = DEF_ROWS_NUM,
    parameter int K_MAX     = DEF_K_MAX,
    parameter int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int K_WIDTH   = DEF_K_WIDTH
) (
    input  logic [NUM_WIDTH-1:0] remainder,
    input  logic [K_WIDTH-1:0]   j,
    output logic [ROW_WIDTH-1:0] row,
    output logic [NUM_WIDTH-1:0] val
);

    logic [K_MAX:1][ROW_WIDTH-1:0] col_row;
    logic [K_MAX:1][NUM_WIDTH-1:0] col_val;

    for (genvar g = 1; g <= K_MAX; g++) begin : g_col
        localparam int COL_INDEX = g;
        logic [ROWS_NUM-1:0][NUM_WIDTH-1:0] tab;
        logic [ROW_WIDTH-1:0] best_row;
        logic [NUM_WIDTH-1:0] best_val;

        for (genvar c = 0; c < ROWS_NUM; c++) begin : g_tab
            assign tab[c] = NUM_WIDTH'(binom(c, COL_INDEX));
        end

        // C(c,k) is non-decreasing in c, so the last hit is the largest fitting row.
        always_comb begin
            best_row = '0;
            best_val = '0;
            for (int c = 0; c < ROWS_NUM; c++) begin
                if (tab[c] <= remainder) begin
                    best_row = ROW_WIDTH'(c);
                    best_val = tab[c];
                end
            end
        end

        assign col_row[g] = best_row;
        assign col_val[g] = best_val;
    end

    always_comb begin
        row = '0;
        val = '0;
        for (int k = 1; k <= K_MAX; k++) begin
            if (j == K_WIDTH'(k)) begin
                row = col_row[k];
                val = col_val[k];
            end
        end
    end

endmodule

// File: rtl/unrank_seq.sv
// Combinadic unranking sequencer: walks columns k..1 and streams one element per step.
module unrank_seq
    import unrank_pkg::*;
#(
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int ROWS_NUM  = DEF_ROWS_NUM,
    parameter int K_MAX     = DEF_K_MAX,
    parameter int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int K_WIDTH   = DEF_K_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k_in,
    input  logic [NUM_WIDTH-1:0] rank_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_WIDTH-1:0] out_elem,
    output logic                 out_last
);

    state_t               state;
    state_t               state_next;
    logic [NUM_WIDTH-1:0] remainder;
    logic [K_WIDTH-1:0]   j;
    logic [ROW_WIDTH-1:0] sel_row;
    logic [NUM_WIDTH-1:0] sel_val;
    logic                 req_bad;

    unrank_colbank #(
        .NUM_WIDTH (NUM_WIDTH),
        .ROWS_NUM  (ROWS_NUM),
        .K_MAX     (K_MAX),
        .ROW_WIDTH (ROW_WIDTH),
        .K_WIDTH   (K_WIDTH)
    ) u_colbank (
        .remainder (remainder),
        .j         (j),
        .row       (sel_row),
        .val       (sel_val)
    );

    // Request is rejected when k is too large or the rank has no k-subset.
    always_comb begin
        req_bad = 1'b0;
        if (32'(j) > 32'(K_MAX)) begin
            req_bad = 1'b1;
        end
        for (int k = 1; k <= K_MAX; k++) begin
            if (j == K_WIDTH'(k) && 32'(remainder) >= BOUND[k]) begin
                req_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = (j == '0 || req_bad) ? FIN : STEP;
            STEP:    state_next = EMIT;
            EMIT:    if (out_ready) state_next = (j == K_WIDTH'(1)) ? FIN : STEP;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remainder <= '0;
            j         <= '0;
            out_elem  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remainder <= rank_in;
                        j         <= k_in;
                        err       <= 1'b0;
                    end
                end
                LOAD: err <= req_bad;
                STEP: begin
                    out_elem  <= sel_row;
                    out_last  <= (j == K_WIDTH'(1));
                    remainder <= remainder - sel_val;
                end
                EMIT: begin
                    if (out_ready && j != K_WIDTH'(1)) begin
                        j <= j - K_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign out_valid = (state == EMIT);

endmodule

// File: tb/tb_unrank_seq.sv
// Randomized self-checking bench for unrank_seq; reference ranks subsets by colex enumeration.
module tb_unrank_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] k_in = '0;
    logic [9:0] rank_in = '0;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic       out_valid;
    logic [3:0] out_elem;
    logic       out_last;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    bit exp_err;

    always #5 clk = ~clk;

    unrank_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_in      (k_in),
        .rank_in   (rank_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_elem  (out_elem),
        .out_last  (out_last)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Subsets of {0..12} ordered by their bitmask value are exactly combinadic order.
    function automatic void modelUnrank(input int k, input int rank);
        int seen;
        exp_q.delete();
        exp_err = 1'b0;
        if (k == 0) return;
        if (k > 4) begin
            exp_err = 1'b1;
            return;
        end
        seen = 0;
        for (int m = 0; m < (1 << 13); m++) begin
            if ($countones(m) == k) begin
                if (seen == rank) begin
                    for (int b = 12; b >= 0; b--) begin
                        if (m[b]) exp_q.push_back(b);
                    end
                    return;
                end
                seen++;
            end
        end
        exp_err = 1'b1;
    endfunction

    function automatic int choose(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_elem"}, out_elem, 0);
    endtask

    // stall < 0: random ready; stall >= 0: ready held low that many cycles per element.
    task automatic applyStimulus(input int k, input int rank, input int stall, input bit ghost);
        int got_e[$];
        int got_l[$];
        int cyc = 0;
        int first_valid = -1;
        int done_cyc = -1;
        int stall_cnt = 0;
        int hold_e = 0;
        int hold_l = 0;
        bit pending = 1'b0;
        bit seen_done = 1'b0;
        bit got_err = 1'b0;
        bit rdy;
        modelUnrank(k, rank);
        @(negedge clk);
        start = 1'b1;
        k_in = 3'(k);
        rank_in = 10'(rank);
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 300) begin
            cyc++;
            if (pending) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_elem", out_elem, hold_e);
                checkOutput("hold_last", out_last, hold_l);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
                got_err = err;
            end
            rdy = (stall < 0) ? 1'($urandom_range(0, 1)) : (stall_cnt >= stall);
            pending = 1'b0;
            if (out_valid) begin
                if (rdy) begin
                    got_e.push_back(out_elem);
                    got_l.push_back(out_last);
                    stall_cnt = 0;
                end else begin
                    pending = 1'b1;
                    hold_e = out_elem;
                    hold_l = out_last;
                    stall_cnt++;
                end
            end
            out_ready = rdy;
            start = 1'b0;
            if (ghost && busy && !done && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                k_in = 3'($urandom);
                rank_in = 10'($urandom);
            end
            if (!seen_done) @(negedge clk);
        end
        start = 1'b0;
        if (!seen_done) checkOutput("timeout", 0, 1);
        checkOutput("err", got_err, exp_err);
        checkOutput("n_elem", got_e.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_e.size()) begin
                checkOutput($sformatf("elem%0d", i), got_e[i], exp_q[i]);
                checkOutput($sformatf("last%0d", i), got_l[i], (i == exp_q.size() - 1) ? 1 : 0);
            end
        end
        if (stall == 0 && seen_done) begin
            if (exp_q.size() > 0) checkOutput("first_valid", first_valid, 3);
            checkOutput("done_cyc", done_cyc, (exp_q.size() > 0) ? 2 * exp_q.size() + 2 : 2);
        end
        @(negedge clk);
        checkOutput("done_pulse", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("err_hold", err, exp_err);
        out_ready = 1'b0;
    endtask

    task automatic resetMidEmit();
        int seen = 0;
        int w = 0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        k_in = 3'd4;
        rank_in = 10'd714;
        @(negedge clk);
        start = 1'b0;
        while (seen < 2 && w < 50) begin
            if (out_valid) seen++;
            if (seen < 2) @(negedge clk);
            w++;
        end
        checkOutput("rst_setup", seen, 2);
        checkOutput("rst_second_elem", out_elem, 11);
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 checkIdleOutputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("rst_no_done", done, 0);
            checkOutput("rst_no_valid", out_valid, 0);
        end
    endtask

    initial begin
        #1 checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3, 10, 0, 1'b0);
        applyStimulus(4, 714, 0, 1'b0);
        applyStimulus(4, 715, 0, 1'b0);
        applyStimulus(5, 0, 0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0);
        applyStimulus(3, 0, 5, 1'b0);
        applyStimulus(4, 300, 0, 1'b1);
        applyStimulus(2, 40, 0, 1'b1);
        resetMidEmit();
        applyStimulus(4, 714, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int k;
            int rank;
            k = $urandom_range(0, 5);
            if ($urandom_range(0, 4) == 0 || k == 0 || k > 4) rank = $urandom_range(0, 1023);
            else rank = $urandom_range(0, choose(13, k) - 1);
            applyStimulus(k, rank, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
